// File: rtl/decision_pkg.sv
// Shared constants and FSM state type for the decision-unit arbiter.
package decision_pkg;
   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_e;
endpackage

// File: rtl/decision_pick.sv
// Combinational winner search over req starting at a given index.
// DECISION_ARB_RR_EN: search ascends from start (round-robin); otherwise it descends from start.
module decision_pick
   import decision_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] win,
   output logic             found
);

   logic [IDX_W-1:0] idx;

   // Scan farthest candidate first so the closest one to start overwrites it.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef DECISION_ARB_RR_EN
         idx = start + IDX_W'(k);
`else
         idx = start - IDX_W'(k);
`endif
         if (req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decision_arbiter.sv
// Four-way arbiter for the shared decision unit: grant, bounded hold, one-cycle gap.
// DECISION_ARB_RR_EN selects round-robin; default build is fixed priority (req[3] highest).
module decision_arbiter
   import decision_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam int               CNT_W   = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             vld_nxt;
   logic             to_nxt;
   logic [IDX_W-1:0] start;
   logic [IDX_W-1:0] win;
   logic             found;

`ifdef DECISION_ARB_RR_EN
   logic [IDX_W-1:0] ptr, ptr_nxt;
   assign start = ptr + IDX_W'(1);
`else
   assign start = IDX_W'(N_REQ - 1);
`endif

   decision_pick u_pick (
      .req   (req),
      .start (start),
      .win   (win),
      .found (found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
`ifdef DECISION_ARB_RR_EN
         ptr       <= IDX_W'(N_REQ - 1);
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= idx_nxt;
         gnt_valid <= vld_nxt;
         timeout   <= to_nxt;
`ifdef DECISION_ARB_RR_EN
         ptr       <= ptr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      vld_nxt   = gnt_valid;
      to_nxt    = 1'b0;
`ifdef DECISION_ARB_RR_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               gnt_nxt   = N_REQ'(1) << win;
               idx_nxt   = win;
               vld_nxt   = 1'b1;
               cnt_nxt   = '0;
`ifdef DECISION_ARB_RR_EN
               ptr_nxt   = win;
`endif
            end
         end
         BUSY: begin
            // A release with the owner still requesting can only be the forced one.
            if (!req[gnt_idx] || cnt == CNT_LIM) begin
               state_nxt = GAP;
               gnt_nxt   = '0;
               idx_nxt   = '0;
               vld_nxt   = 1'b0;
               cnt_nxt   = '0;
               to_nxt    = req[gnt_idx];
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
